// File: rtl/fpcvt_rr_scheduler_if.sv
// fpcvt_rr_scheduler_if: handshake bundle between the two sample sources, the scheduler and the consumer.
//   req0_valid/req0_data/req0_ready : requester 0 sample channel (12-bit two's complement)
//   req1_valid/req1_data/req1_ready : requester 1 sample channel (12-bit two's complement)
//   out_valid/out_ready             : converted result handshake
//   out_src/out_s/out_e/out_f       : result source tag and 8-bit float fields
//   master = sources/consumer side, slave = scheduler side
interface fpcvt_rr_scheduler_if;
   logic        req0_valid;
   logic [11:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [11:0] req1_data;
   logic        req1_ready;
   logic        out_valid;
   logic        out_ready;
   logic        out_src;
   logic        out_s;
   logic [2:0]  out_e;
   logic [3:0]  out_f;
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, out_ready,
      input  req0_ready, req1_ready, out_valid, out_src, out_s, out_e, out_f
   );
   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
      output req0_ready, req1_ready, out_valid, out_src, out_s, out_e, out_f
   );
endinterface

// File: rtl/fpcvt_rr_scheduler.sv
// fpcvt_rr_scheduler: round-robin sharing of one 12-bit to 8-bit float converter between two requesters.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   bus    : slave side of fpcvt_rr_scheduler_if (two request channels, one result channel)
//   cnt0_o : samples accepted from requester 0 (wraps)
//   cnt1_o : samples accepted from requester 1 (wraps)
module fpcvt_rr_scheduler #(
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   fpcvt_rr_scheduler_if.slave  bus,
   output logic [CNT_W-1:0]     cnt0_o,
   output logic [CNT_W-1:0]     cnt1_o
);
   logic             a_valid_q, a_valid_d, a_src_q, a_src_d;
   logic [11:0]      a_data_q, a_data_d;
   logic             b_valid_q, b_valid_d, b_src_q, b_src_d, b_s_q, b_s_d;
   logic [2:0]       b_e_q, b_e_d;
   logic [3:0]       b_f_q, b_f_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic             b_load, a_accept, gnt, xfer0, xfer1;
   logic             cv_s;
   logic [2:0]       cv_e;
   logic [3:0]       cv_f;
   logic [11:0]      mag12, rbits;
   logic [10:0]      mag;
   logic [4:0]       rsum;

   // Shared converter. The most-negative input has no positive twin, so the
   // magnitude is clamped to 0x7FF; the exponent is the position of the leading
   // one above bit 3, and the bit just below the 4-bit significand rounds it.
   always_comb begin
      cv_s  = a_data_q[11];
      mag12 = cv_s ? (~a_data_q + 12'd1) : a_data_q;
      mag   = mag12[11] ? 11'h7FF : mag12[10:0];
      cv_e  = 3'd0;
      for (int i = 4; i <= 10; i++)
         if (mag[i]) cv_e = 3'(i - 3);
      rbits = {mag, 1'b0} >> cv_e;
      rsum  = {1'b0, rbits[4:1]} + {4'd0, rbits[0]};
      cv_f  = rsum[3:0];
      if (rsum[4]) begin
         cv_f = (cv_e == 3'd7) ? 4'hF : 4'h8;
         cv_e = (cv_e == 3'd7) ? 3'd7 : cv_e + 3'd1;
      end
   end

   always_comb begin
      b_load    = a_valid_q & (~b_valid_q | bus.out_ready);
      a_accept  = ~a_valid_q | b_load;
      // A lone requester wins; a contested cycle goes to whoever was not granted last.
      gnt       = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
      xfer0     = a_accept & bus.req0_valid & ~gnt & ~rst;
      xfer1     = a_accept & bus.req1_valid & gnt & ~rst;
      a_valid_d = xfer0 | xfer1 | (a_valid_q & ~b_load);
      a_data_d  = xfer1 ? bus.req1_data : xfer0 ? bus.req0_data : a_data_q;
      a_src_d   = xfer1 ? 1'b1 : xfer0 ? 1'b0 : a_src_q;
      last_d    = xfer1 ? 1'b1 : xfer0 ? 1'b0 : last_q;
      b_valid_d = b_load | (b_valid_q & ~bus.out_ready);
      b_src_d   = b_load ? a_src_q : b_src_q;
      b_s_d     = b_load ? cv_s : b_s_q;
      b_e_d     = b_load ? cv_e : b_e_q;
      b_f_d     = b_load ? cv_f : b_f_q;
      cnt0_d    = cnt0_q + CNT_W'(xfer0);
      cnt1_d    = cnt1_q + CNT_W'(xfer1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_q <= 1'b0;
         a_data_q  <= '0;
         a_src_q   <= 1'b0;
         b_valid_q <= 1'b0;
         b_src_q   <= 1'b0;
         b_s_q     <= 1'b0;
         b_e_q     <= '0;
         b_f_q     <= '0;
         last_q    <= 1'b1;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         a_valid_q <= a_valid_d;
         a_data_q  <= a_data_d;
         a_src_q   <= a_src_d;
         b_valid_q <= b_valid_d;
         b_src_q   <= b_src_d;
         b_s_q     <= b_s_d;
         b_e_q     <= b_e_d;
         b_f_q     <= b_f_d;
         last_q    <= last_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
      end
   end

   assign bus.req0_ready = xfer0;
   assign bus.req1_ready = xfer1;
   assign bus.out_valid  = b_valid_q;
   assign bus.out_src    = b_src_q;
   assign bus.out_s      = b_s_q;
   assign bus.out_e      = b_e_q;
   assign bus.out_f      = b_f_q;
   assign cnt0_o         = cnt0_q;
   assign cnt1_o         = cnt1_q;
endmodule

// File: doc/fpcvt_rr_scheduler.md
Name: fpcvt_rr_scheduler

Overview:
Shares one instance of the team's combinational 12-bit two's-complement to 8-bit float converter (FPCVT: D in; S, E, F out) between two requesters. Arbitration is round-robin. The block is a two-stage valid/ready pipeline:
- Stage A captures the granted raw sample.
- Stage B registers the converted float together with its source tag.
It sits between the sample sources (switch/sample front ends) and the display/consumer logic, and keeps per-source conversion counters.

Parameters:
CNT_W, 8, width of each per-source accepted-sample counter (wraps modulo 2^CNT_W)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a sample
- req0_data  input  12  requester 0 sample, two's complement
- req0_ready  output  1  requester 0 sample accepted this cycle (when valid)
- req1_valid  input  1  requester 1 has a sample
- req1_data  input  12  requester 1 sample, two's complement
- req1_ready  output  1  requester 1 sample accepted this cycle (when valid)
- out_valid  output  1  converted result available
- out_ready  input  1  consumer accepts result
- out_src  output  1  source of result (0 = req0, 1 = req1)
- out_s  output  1  float sign
- out_e  output  3  float exponent
- out_f  output  4  float significand
- cnt0  output  CNT_W  samples accepted from requester 0
- cnt1  output  CNT_W  samples accepted from requester 1

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - a_valid=0, b_valid=0, so out_valid=0.
  - out_src, out_s, out_e, out_f = 0.
  - cnt0 = cnt1 = 0.
  - last_grant = 1, so requester 0 wins the first contested cycle.
  - In-flight samples are discarded; no output is produced for them after reset.
  - req*_ready = 0 while rst=1.
- Stage-B load enable: b_load = a_valid & (!b_valid | out_ready).
- Stage-A accept enable: a_accept = !a_valid | b_load.
- Arbitration (combinational, in the same cycle):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant = !last_grant.
  - Neither valid: no grant.
- reqN_ready = a_accept & grant==N & !rst. Ready may depend on valid. The ungranted requester sees ready=0 and must hold its data.
- On a transfer (reqN_valid & reqN_ready):
  - Stage A loads data and src=N; a_valid=1.
  - last_grant <= N.
  - cntN increments, wrapping from 2^CNT_W-1 to 0.
- last_grant is unchanged on cycles with no transfer.
- Conversion:
  - The converter is driven combinationally from the stage-A data register.
  - On b_load, stage B registers S/E/F and src, and b_valid=1.
  - Otherwise stage B holds, and out_* are stable while out_valid & !out_ready.
- If a_valid & !b_load, stage A holds and a_valid stays 1.
- b_valid clears when out_ready & !b_load.
- Latency: a sample accepted at edge k appears on out_* after edge k+1, i.e. out_valid is high in the cycle after stage A loads, provided the output is not stalled.
- Throughput: 1 result per cycle with out_ready held high.
- Backpressure: with out_ready=0, at most 2 samples are buffered (A and B). After that, both req*_ready=0.
- Simultaneous events:
  - Stage A may load a new sample on the same edge it passes its current sample to stage B.
  - Stage B may load on the same edge its current result is consumed.
- Fairness: with both requesters valid continuously and no stall, grants alternate 0,1,0,1,...
- Conversion semantics are exactly those of the shared converter, including:
  - most-negative input 0x800 → S=1, E=7, F=15
  - round-up overflow saturating at E=7, F=15.

Test Plan:
- Reset, then req0 only, D=0x02C, out_ready=1 → out_valid two cycles after transfer; src=0, S=0, E=2, F=11; cnt0=1, cnt1=0.
- req1 only, D=0x07D → src=1, S=0, E=4, F=8 (rounding carry into exponent). Then D=0xFFF → S=1, E=0, F=1.
- Both requesters valid every cycle for 6 cycles (req0 D=0x800, req1 D=0x000), out_ready=1 → grants alternate 0,1,0,1,0,1.
  - req0 results: S=1, E=7, F=15.
  - req1 results: S=0, E=0, F=0.
  - cnt0 = cnt1 = 3.
- out_ready=0 with req0 valid continuously → exactly 2 transfers, then req0_ready=0; out_* held stable. Raise out_ready → results drain in order with no loss or duplication.
- Assert rst for 1 cycle while a_valid=b_valid=1 → out_valid=0 and counters=0 after the edge; next contested grant goes to requester 0.
- CNT_W=2, 5 req0 transfers → cnt0 sequence 1,2,3,0,1.
